// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks which architectural registers have a write
// in flight. Issue sets an entry busy, writeback clears it, flush and reset
// clear everything. Source-operand queries see a same-cycle writeback as
// already complete, so a consumer does not stall on a value being written.
module reg_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NREGS    = 2 ** ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [NREGS-1:0]  busy_vec,
    output logic [ADDR_W:0]   busy_count,
    output logic [NREGS-1:0]  issue_onehot
);

    // Full address space, so any address can index without a range check;
    // entries at or above NREGS simply read as never busy.
    localparam int FULL = 1 << ADDR_W;
    localparam logic [ADDR_W:0] NREGS_L = (ADDR_W + 1)'(NREGS);

    // An entry is trackable if it exists and is not the hardwired zero register.
    function automatic logic trackable(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + (ADDR_W + 1)'(v[i]);
        end
        return c;
    endfunction

    logic [FULL-1:0]   busy_full;
    logic [FULL-1:0]   set_full;
    logic [FULL-1:0]   next_full;
    logic [NREGS-1:0]  busy_next;
    logic [ADDR_W:0]   count_next;
    logic              accept;

    // Zero-extend the tracked entries to the full address space.
    always_comb begin
        busy_full = '0;
        busy_full[NREGS-1:0] = busy_vec;
    end

    // Issue handshake, accepted-entry decode and source-operand lookups.
    always_comb begin
        issue_ready = !busy_full[issue_addr] || (wb_valid && (wb_addr == issue_addr));
        accept      = issue_valid && issue_ready;
        set_full    = '0;
        if (accept && trackable(issue_addr)) begin
            set_full[issue_addr] = 1'b1;
        end
        issue_onehot = set_full[NREGS-1:0];
        rs_busy = busy_full[rs_addr] && !(wb_valid && (wb_addr == rs_addr));
        rt_busy = busy_full[rt_addr] && !(wb_valid && (wb_addr == rt_addr));
    end

    // Next busy state: clear on writeback, then set on accept so a
    // same-entry issue wins; flush squashes everything.
    always_comb begin
        next_full = busy_full;
        if (wb_valid) begin
            next_full[wb_addr] = 1'b0;
        end
        next_full = next_full | set_full;
        if (flush) begin
            next_full = '0;
        end
        if (ZERO_REG != 0) begin
            next_full[0] = 1'b0;
        end
        busy_next  = next_full[NREGS-1:0];
        count_next = popcount(busy_next);
    end

    // Busy bits and their count are registered together so they always agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_vec   <= '0;
            busy_count <= '0;
        end else begin
            busy_vec   <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed scenarios plus a randomized run
// checked against an array-based model of the busy table.
module tb_reg_scoreboard;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_busy;
    logic        rt_busy;
    logic [31:0] busy_vec;
    logic [5:0]  busy_count;
    logic [31:0] issue_onehot;

    int n_checks = 0;
    int n_pass   = 0;

    reg_scoreboard #(.ADDR_W(5), .NREGS(32), .ZERO_REG(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .busy_vec     (busy_vec),
        .busy_count   (busy_count),
        .issue_onehot (issue_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        reset = 0; flush = 0; issue_valid = 0; issue_addr = 0;
        wb_valid = 0; wb_addr = 0; rs_addr = 0; rt_addr = 0;
    endtask

    // Advance one cycle; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a);
        idle(); issue_valid = 1; issue_addr = a;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1; issue_valid = 1; issue_addr = 5'd7; wb_valid = 1; wb_addr = 5'd3;
        tick();
        tick();
        rs_addr = 5'd7; rt_addr = 5'd3;
        #1;
        n_checks++; if (busy_vec !== 32'h0) $display("FAIL reset_vec: got %h want 0", busy_vec); else n_pass++;
        n_checks++; if (busy_count !== 6'd0) $display("FAIL reset_count: got %0d want 0", busy_count); else n_pass++;
        n_checks++; if (issue_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", issue_ready); else n_pass++;
        n_checks++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) $display("FAIL reset_rsrt: got %b%b want 00", rs_busy, rt_busy); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_issue_basic();
        issue(5'd8);
        idle(); rs_addr = 5'd8; rt_addr = 5'd9;
        #1;
        n_checks++; if (busy_vec !== 32'h0000_0100) $display("FAIL issue8_vec: got %h want 00000100", busy_vec); else n_pass++;
        n_checks++; if (busy_count !== 6'd1) $display("FAIL issue8_count: got %0d want 1", busy_count); else n_pass++;
        n_checks++; if (rs_busy !== 1'b1) $display("FAIL issue8_rs: got %b want 1", rs_busy); else n_pass++;
        n_checks++; if (rt_busy !== 1'b0) $display("FAIL issue8_rt: got %b want 0", rt_busy); else n_pass++;
    endtask

    task automatic test_waw_stall();
        idle(); issue_valid = 1; issue_addr = 5'd8;
        #1;
        n_checks++; if (issue_ready !== 1'b0) $display("FAIL waw_ready: got %b want 0", issue_ready); else n_pass++;
        n_checks++; if (issue_onehot !== 32'h0) $display("FAIL waw_onehot: got %h want 0", issue_onehot); else n_pass++;
        tick();
        n_checks++; if (busy_vec !== 32'h0000_0100) $display("FAIL waw_hold: got %h want 00000100", busy_vec); else n_pass++;
        wb_valid = 1; wb_addr = 5'd8;
        #1;
        n_checks++; if (issue_ready !== 1'b1) $display("FAIL waw_wb_ready: got %b want 1", issue_ready); else n_pass++;
        n_checks++; if (issue_onehot !== 32'h0000_0100) $display("FAIL waw_wb_onehot: got %h want 00000100", issue_onehot); else n_pass++;
        tick();
        n_checks++; if (busy_vec !== 32'h0000_0100 || busy_count !== 6'd1) $display("FAIL set_wins: got %h/%0d want 00000100/1", busy_vec, busy_count); else n_pass++;
    endtask

    task automatic test_wb_bypass();
        issue(5'd5);
        idle(); wb_valid = 1; wb_addr = 5'd5; rs_addr = 5'd5; rt_addr = 5'd8;
        #1;
        n_checks++; if (rs_busy !== 1'b0) $display("FAIL bypass_rs: got %b want 0", rs_busy); else n_pass++;
        n_checks++; if (rt_busy !== 1'b1) $display("FAIL bypass_rt: got %b want 1", rt_busy); else n_pass++;
        tick();
        n_checks++; if (busy_vec !== 32'h0000_0100 || busy_count !== 6'd1) $display("FAIL bypass_clear: got %h/%0d want 00000100/1", busy_vec, busy_count); else n_pass++;
    endtask

    task automatic test_zero_reg();
        idle(); issue_valid = 1; issue_addr = 5'd0; rs_addr = 5'd0;
        #1;
        n_checks++; if (issue_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", issue_ready); else n_pass++;
        n_checks++; if (issue_onehot !== 32'h0) $display("FAIL zero_onehot: got %h want 0", issue_onehot); else n_pass++;
        tick();
        n_checks++; if (busy_vec !== 32'h0000_0100 || rs_busy !== 1'b0) $display("FAIL zero_state: got %h rs=%b want 00000100 rs=0", busy_vec, rs_busy); else n_pass++;
    endtask

    task automatic test_fill_flush();
        idle(); reset = 1;
        tick();
        for (int i = 1; i < 32; i++) issue(5'(i));
        idle();
        n_checks++; if (busy_count !== 6'd31) $display("FAIL fill_count: got %0d want 31", busy_count); else n_pass++;
        n_checks++; if (busy_vec !== 32'hFFFF_FFFE) $display("FAIL fill_vec: got %h want fffffffe", busy_vec); else n_pass++;
        wb_valid = 1; wb_addr = 5'd3; issue_valid = 1; issue_addr = 5'd3; flush = 1;
        tick();
        idle();
        n_checks++; if (busy_vec !== 32'h0 || busy_count !== 6'd0) $display("FAIL flush: got %h/%0d want 0/0", busy_vec, busy_count); else n_pass++;
    endtask

    task automatic test_reset_pending();
        issue(5'd2);
        issue(5'd9);
        idle();
        n_checks++; if (busy_vec !== 32'h0000_0204) $display("FAIL pend_vec: got %h want 00000204", busy_vec); else n_pass++;
        reset = 1; issue_valid = 1; issue_addr = 5'd4;
        tick();
        idle();
        n_checks++; if (busy_vec !== 32'h0 || busy_count !== 6'd0) $display("FAIL reset_pend: got %h/%0d want 0/0", busy_vec, busy_count); else n_pass++;
        wb_valid = 1; wb_addr = 5'd9;
        tick();
        idle();
        n_checks++; if (busy_vec !== 32'h0 || busy_count !== 6'd0) $display("FAIL late_wb: got %h/%0d want 0/0", busy_vec, busy_count); else n_pass++;
    endtask

    task automatic test_random();
        bit          mdl [32];
        bit          acc;
        logic [31:0] exp_vec;
        logic [31:0] exp_oh;
        int          cnt;
        idle(); reset = 1;
        tick();
        foreach (mdl[i]) mdl[i] = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset       = ($urandom_range(0, 59) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_addr  = 5'($urandom_range(0, 31));
            wb_valid    = $urandom_range(0, 2) != 0;
            wb_addr     = ($urandom_range(0, 2) == 0) ? issue_addr : 5'($urandom_range(0, 31));
            rs_addr     = ($urandom_range(0, 2) == 0) ? wb_addr : 5'($urandom_range(0, 31));
            rt_addr     = 5'($urandom_range(0, 31));
            #1;
            acc    = issue_valid && (!mdl[issue_addr] || (wb_valid && wb_addr == issue_addr));
            exp_oh = (acc && issue_addr != 0) ? (32'h1 << issue_addr) : 32'h0;
            n_checks++; if (issue_ready !== (!mdl[issue_addr] || (wb_valid && wb_addr == issue_addr)))
                $display("FAIL rnd_ready cyc%0d: got %b addr %0d", cyc, issue_ready, issue_addr); else n_pass++;
            n_checks++; if (rs_busy !== (mdl[rs_addr] && !(wb_valid && wb_addr == rs_addr)))
                $display("FAIL rnd_rs cyc%0d: got %b addr %0d", cyc, rs_busy, rs_addr); else n_pass++;
            n_checks++; if (rt_busy !== (mdl[rt_addr] && !(wb_valid && wb_addr == rt_addr)))
                $display("FAIL rnd_rt cyc%0d: got %b addr %0d", cyc, rt_busy, rt_addr); else n_pass++;
            n_checks++; if (issue_onehot !== exp_oh)
                $display("FAIL rnd_onehot cyc%0d: got %h want %h", cyc, issue_onehot, exp_oh); else n_pass++;
            if (reset || flush) begin
                foreach (mdl[i]) mdl[i] = 0;
            end else begin
                if (wb_valid) mdl[wb_addr] = 0;
                if (acc && issue_addr != 0) mdl[issue_addr] = 1;
            end
            tick();
            exp_vec = '0;
            cnt = 0;
            foreach (mdl[i]) begin
                exp_vec[i] = mdl[i];
                cnt += int'(mdl[i]);
            end
            n_checks++; if (busy_vec !== exp_vec)
                $display("FAIL rnd_vec cyc%0d: got %h want %h", cyc, busy_vec, exp_vec); else n_pass++;
            n_checks++; if (busy_count !== 6'(cnt))
                $display("FAIL rnd_count cyc%0d: got %0d want %0d", cyc, busy_count, cnt); else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_issue_basic();
        test_waw_stall();
        test_wb_bypass();
        test_zero_reg();
        test_fill_flush();
        test_reset_pending();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
